// File: rtl/mult_pipe_pkg.sv
// Shared constants and helpers for the multiplier pipeline controller.
//   MP_DEPTH / MP_TAG_W / MP_CNT_W : default stage count, tag width and
//                                    completed-operation counter width
//   CNT_IN_W                       : width of the in-flight count for MP_DEPTH
//   popcount()                     : number of set bits in a stage-valid vector
package mult_pipe_pkg;

    localparam int MP_DEPTH  = 4;
    localparam int MP_TAG_W  = 4;
    localparam int MP_CNT_W  = 16;
    localparam int CNT_IN_W  = $clog2(MP_DEPTH + 1);

    // popcount() accepts valid vectors up to this many stages.
    localparam int POP_MAX_W = 32;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] i_bits);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + {31'd0, i_bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mult_pipe_ctrl_slot.sv
// pipe_slot: occupancy bit plus sideband tag for one multiplier stage.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clr        : synchronous clear of the occupancy bit (flush); tag kept
//   i_en         : load enable, same signal that gates this stage's dff bank
//   i_valid/i_tag: values from the previous stage (or the input port)
//   o_valid/o_tag: registered occupancy and tag
module pipe_slot #(
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag
);

    logic             r_valid;
    logic [TAG_W-1:0] r_tag;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
        end else if (i_clr) begin
            // Flush drops occupancy only; the tag register is left alone.
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_tag   <= i_tag;
        end
    end

    assign o_valid = r_valid;
    assign o_tag   = r_tag;

endmodule

// File: rtl/mult_pipe_ctrl.sv
// mult_pipe_ctrl: occupancy/enable controller for a DEPTH-stage registered
// multiplier. Holds no datapath bits; stage i's dff bank loads on stage_en[i].
//   clk, rst             : clock, asynchronous active-high reset
//   flush                : synchronous discard of every in-flight operation
//   in_valid/in_ready    : upstream handshake, in_tag is the sideband tag
//   stage_en             : per-stage load enables for the datapath
//   stage_valid          : per-stage occupancy
//   out_valid/out_ready  : downstream handshake, out_tag is the result's tag
//   in_flight, busy      : occupied-stage count and any-occupied flag
//   done_count           : products accepted downstream, wraps
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready never depends on in_valid. Once out_valid is high it and
// out_tag hold until the transfer, unless flush or reset intervenes.
module mult_pipe_ctrl
    import mult_pipe_pkg::*;
#(
    parameter int DEPTH = MP_DEPTH,
    parameter int TAG_W = MP_TAG_W,
    parameter int CNT_W = MP_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TAG_W-1:0]           in_tag,
    output logic [DEPTH-1:0]           stage_en,
    output logic [DEPTH-1:0]           stage_valid,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] in_flight,
    output logic                       busy,
    output logic [CNT_W-1:0]           done_count
);

    localparam int IN_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_en;
    logic [DEPTH-1:0] w_stage_en;
    logic [TAG_W-1:0] w_tag [DEPTH];
    logic             w_complete;
    logic [CNT_W-1:0] r_done_count;

    // A stage may load when it is empty or when the stage after it is loading
    // too; the chain starts from the output handshake. Empty stages therefore
    // always load, which squeezes bubbles out under backpressure.
    always_comb begin
        w_en = '0;
        w_en[DEPTH-1] = ~w_valid[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_en[i] = ~w_valid[i] | w_en[i+1];
        end
    end

    assign w_stage_en = w_en & ~{DEPTH{flush}};

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic             w_d_valid;
        logic [TAG_W-1:0] w_d_tag;

        if (g == 0) begin : g_head
            assign w_d_valid = in_valid;
            assign w_d_tag   = in_tag;
        end else begin : g_body
            assign w_d_valid = w_valid[g-1];
            assign w_d_tag   = w_tag[g-1];
        end

        pipe_slot #(
            .TAG_W (TAG_W)
        ) u_slot (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_clr   (flush),
            .i_en    (w_stage_en[g]),
            .i_valid (w_d_valid),
            .i_tag   (w_d_tag),
            .o_valid (w_valid[g]),
            .o_tag   (w_tag[g])
        );
    end

    assign w_complete = w_valid[DEPTH-1] & out_ready & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_count <= '0;
        end else if (w_complete) begin
            r_done_count <= r_done_count + 1'b1;
        end
    end

    assign in_ready    = w_en[0] & ~flush;
    assign stage_en    = w_stage_en;
    assign stage_valid = w_valid;
    assign out_valid   = w_valid[DEPTH-1];
    assign out_tag     = w_tag[DEPTH-1];
    assign in_flight   = IN_W'(popcount(POP_MAX_W'(w_valid)));
    assign busy        = |w_valid;
    assign done_count  = r_done_count;

endmodule

// File: tb/tb_mult_pipe_ctrl.sv
module tb_mult_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_tag;
    logic [3:0]  stage_en;
    logic [3:0]  stage_valid;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_tag;
    logic [2:0]  in_flight;
    logic        busy;
    logic [15:0] done_count;

    // Second instance with a 4-bit completion counter for the wrap scenario.
    logic        w_flush;
    logic        w_in_valid;
    logic        w_in_ready;
    logic [3:0]  w_in_tag;
    logic [3:0]  w_stage_en;
    logic [3:0]  w_stage_valid;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [3:0]  w_out_tag;
    logic [2:0]  w_in_flight;
    logic        w_busy;
    logic [3:0]  w_done_count;

    int n_checks = 0;
    int n_errors = 0;

    mult_pipe_ctrl #(.DEPTH(4), .TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .stage_en(stage_en), .stage_valid(stage_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .in_flight(in_flight), .busy(busy), .done_count(done_count)
    );

    mult_pipe_ctrl #(.DEPTH(4), .TAG_W(4), .CNT_W(4)) dut_wrap (
        .clk(clk), .rst(rst), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_tag(w_in_tag),
        .stage_en(w_stage_en), .stage_valid(w_stage_valid),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_tag(w_out_tag),
        .in_flight(w_in_flight), .busy(w_busy), .done_count(w_done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every window starts 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_tag = '0; out_ready = 1'b0;
        w_flush = 1'b0; w_in_valid = 1'b0; w_in_tag = '0; w_out_ready = 1'b0;
        #3;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (in_flight !== 3'd0) begin n_errors++; $display("FAIL reset_in_flight: got %0d want 0", in_flight); end
        n_checks++; if (out_tag !== 4'h0) begin n_errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        n_checks++; if (done_count !== 16'd0) begin n_errors++; $display("FAIL reset_done_count: got %0d want 0", done_count); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        logic exp_v;
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 8);
            in_tag   = 4'(c);
            #1;
            exp_v = (c >= 4) && (c < 12);
            n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL stream_in_ready c=%0d: got %b want 1", c, in_ready); end
            n_checks++; if (out_valid !== exp_v) begin n_errors++; $display("FAIL stream_out_valid c=%0d: got %b want %b", c, out_valid, exp_v); end
            if (exp_v) begin
                n_checks++; if (out_tag !== 4'(c - 4)) begin n_errors++; $display("FAIL stream_out_tag c=%0d: got %h want %h", c, out_tag, 4'(c - 4)); end
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_checks++; if (done_count !== 16'd8) begin n_errors++; $display("FAIL stream_done_count: got %0d want 8", done_count); end
    endtask

    task automatic test_fill_stall();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_tag   = 4'(c + 1);
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL fill_in_ready c=%0d: got %b want 1", c, in_ready); end
            tick();
        end
        in_valid = 1'b1; in_tag = 4'd5;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        n_checks++; if (stage_valid !== 4'b1111) begin n_errors++; $display("FAIL stall_stage_valid: got %b want 1111", stage_valid); end
        n_checks++; if (in_flight !== 3'd4) begin n_errors++; $display("FAIL stall_in_flight: got %0d want 4", in_flight); end
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stall_out_valid: got %b want 1", out_valid); end
        n_checks++; if (out_tag !== 4'd1) begin n_errors++; $display("FAIL stall_out_tag: got %h want 1", out_tag); end
        tick();
        #1;
        n_checks++; if (out_tag !== 4'd1) begin n_errors++; $display("FAIL stall_hold_tag: got %h want 1", out_tag); end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_hold_in_ready: got %b want 0", in_ready); end
        tick();
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_tag !== 4'd1) begin n_errors++; $display("FAIL release_out_tag0: got %h want 1", out_tag); end
        tick();
        in_valid = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            #1;
            n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL drain_out_valid k=%0d: got %b want 1", k, out_valid); end
            n_checks++; if (out_tag !== 4'(k)) begin n_errors++; $display("FAIL drain_out_tag: got %h want %h", out_tag, 4'(k)); end
            tick();
        end
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL drain_empty: got %b want 0", out_valid); end
        n_checks++; if (done_count !== 16'd13) begin n_errors++; $display("FAIL fill_done_count: got %0d want 13", done_count); end
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        in_valid = 1'b1; in_tag = 4'hA; tick();
        in_valid = 1'b0; tick();
        tick();
        in_valid = 1'b1; in_tag = 4'hB; tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        n_checks++; if (out_tag !== 4'hA) begin n_errors++; $display("FAIL bubble_a_last: got %h want a", out_tag); end
        tick();
        tick();
        tick();
        #1;
        n_checks++; if (stage_valid !== 4'b1100) begin n_errors++; $display("FAIL bubble_stage_valid: got %b want 1100", stage_valid); end
        n_checks++; if (in_flight !== 3'd2) begin n_errors++; $display("FAIL bubble_in_flight: got %0d want 2", in_flight); end
        n_checks++; if (out_tag !== 4'hA) begin n_errors++; $display("FAIL bubble_out_tag: got %h want a", out_tag); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bubble_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        tick();
        #1;
        n_checks++; if (out_valid !== 1'b1 || out_tag !== 4'hB) begin n_errors++; $display("FAIL bubble_b_out: got v=%b tag=%h want v=1 tag=b", out_valid, out_tag); end
        tick();
        #1;
        n_checks++; if (done_count !== 16'd15) begin n_errors++; $display("FAIL bubble_done_count: got %0d want 15", done_count); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL bubble_busy: got %b want 0", busy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        in_valid = 1'b1; in_tag = 4'd1; tick();
        in_tag = 4'd2; tick();
        in_valid = 1'b0; tick();
        in_valid = 1'b1; in_tag = 4'd3; tick();
        flush = 1'b1; in_valid = 1'b1; in_tag = 4'd7;
        #1;
        n_checks++; if (in_flight !== 3'd3) begin n_errors++; $display("FAIL flush_pre_in_flight: got %0d want 3", in_flight); end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        n_checks++; if (stage_en !== 4'b0000) begin n_errors++; $display("FAIL flush_stage_en: got %b want 0000", stage_en); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++; if (stage_valid !== 4'b0000) begin n_errors++; $display("FAIL flush_stage_valid: got %b want 0000", stage_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL flush_busy: got %b want 0", busy); end
        n_checks++; if (done_count !== 16'd15) begin n_errors++; $display("FAIL flush_done_count: got %0d want 15", done_count); end
        n_checks++; if (out_tag !== 4'd1) begin n_errors++; $display("FAIL flush_tag_kept: got %h want 1", out_tag); end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_tag = 4'(c + 1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1 || done_count !== 16'd16) begin n_errors++; $display("FAIL areset_pre: got v=%b cnt=%0d want v=1 cnt=16", out_valid, done_count); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL areset_busy: got %b want 0", busy); end
        n_checks++; if (done_count !== 16'd0) begin n_errors++; $display("FAIL areset_done_count: got %0d want 0", done_count); end
        #1;
        rst = 1'b0;
        tick();
        in_valid = 1'b1; in_tag = 4'd9;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < 4; c++) begin
            #1;
            n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL areset_early c=%0d: got %b want 0", c, out_valid); end
            tick();
        end
        #1;
        n_checks++; if (out_valid !== 1'b1 || out_tag !== 4'd9) begin n_errors++; $display("FAIL areset_op9: got v=%b tag=%h want v=1 tag=9", out_valid, out_tag); end
        tick();
        #1;
        n_checks++; if (done_count !== 16'd1) begin n_errors++; $display("FAIL areset_done_count_after: got %0d want 1", done_count); end
    endtask

    task automatic test_counter_wrap();
        w_out_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            w_in_valid = (c < 17);
            w_in_tag   = 4'(c);
            tick();
        end
        w_in_valid = 1'b0;
        #1;
        n_checks++; if (w_done_count !== 4'd1) begin n_errors++; $display("FAIL wrap_done_count: got %0d want 1", w_done_count); end
        n_checks++; if (w_busy !== 1'b0) begin n_errors++; $display("FAIL wrap_busy: got %b want 0", w_busy); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill_stall();
        test_bubble();
        test_flush();
        test_async_reset();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
